// File: rtl/board_display_scan_pkg.sv
// Shared cell codes, row indices, scan states and the cell decoder for board_display_scan.
package board_display_scan_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b11;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;
    localparam logic [1:0] CELL_BAD   = 2'b00;

    localparam logic [1:0] ROW0 = 2'd0;
    localparam logic [1:0] ROW1 = 2'd1;
    localparam logic [1:0] ROW2 = 2'd2;

    typedef enum logic {StBlank, StShow} scan_state_e;

    // Returns {red, green} for one active-low {p1_n, p2_n} cell code.
    function automatic logic [1:0] cell_decode(input logic [1:0] code);
        logic [1:0] rg;
        case (code)
            CELL_P1:              rg = 2'b10;
            CELL_P2:              rg = 2'b01;
            CELL_EMPTY, CELL_BAD: rg = 2'b00;
            default:              rg = 2'b00;
        endcase
        return rg;
    endfunction

endpackage

// File: rtl/board_display_scan_row_mux.sv
// Combinational column generator: picks one row of the snapshot and applies the blink masks.
module display_row_mux
    import board_display_scan_pkg::*;
(
    input  logic [1:0]  row,
    input  logic [17:0] snap,
    input  logic        red_off,
    input  logic        green_off,
    output logic [2:0]  red,
    output logic [2:0]  green
);

    logic [5:0] row_bits;

    always_comb begin
        case (row)
            ROW0:    row_bits = snap[17:12];
            ROW1:    row_bits = snap[11:6];
            ROW2:    row_bits = snap[5:0];
            default: row_bits = {3{CELL_EMPTY}};
        endcase
    end

    // Column 0 (left) is the first cell of the row, held in the top bits of the slice.
    for (genvar c = 0; c < 3; c++) begin : g_col
        logic [1:0] rg;
        assign rg       = cell_decode(row_bits[5-2*c -: 2]);
        assign red[c]   = rg[1] & ~red_off;
        assign green[c] = rg[0] & ~green_off;
    end

endmodule

// File: rtl/board_display_scan.sv
// Row-multiplexed 3x3 bicolour LED scanner with per-frame snapshot, blink and sticky code error.
// Optional PWM dimming via the `bright` port when DISPLAY_DIM_EN is defined.
module board_display_scan
    import board_display_scan_pkg::*;
#(
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK        = 2,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] cells_n,
    input  logic        p1_win_n,
    input  logic        p2_win_n,
    input  logic        grid_full_n,
`ifdef DISPLAY_DIM_EN
    input  logic [1:0]  bright,
`endif
    output logic [2:0]  row_sel,
    output logic [2:0]  col_red,
    output logic [2:0]  col_green,
    output logic        frame_tick,
    output logic        code_err
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    row_q, row_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          start_q;
    logic [17:0]   snap_q, snap_d;
    logic [2:0]    stat_n_q, stat_n_d;
    logic          code_err_d;
    logic          row_end, frame_wrap, frame_start, bad;
    logic          p1w, p2w, draw, red_off, green_off, col_en;
    logic [2:0]    mux_red, mux_green;
    logic [2:0]    row_sel_d, col_red_d, col_green_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StBlank;
            cnt_q      <= '0;
            row_q      <= ROW0;
            blink_q    <= '0;
            phase_q    <= 1'b0;
            start_q    <= 1'b1;
            snap_q     <= '1;
            stat_n_q   <= '1;
            row_sel    <= '0;
            col_red    <= '0;
            col_green  <= '0;
            frame_tick <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            start_q    <= 1'b0;
            snap_q     <= snap_d;
            stat_n_q   <= stat_n_d;
            row_sel    <= row_sel_d;
            col_red    <= col_red_d;
            col_green  <= col_green_d;
            frame_tick <= frame_start;
            code_err   <= code_err_d;
        end
    end

    // The first cycle out of reset opens frame 0 in place, so the counter holds at 0.
    always_comb begin
        row_end     = (cnt_q == CNT_LAST);
        frame_wrap  = row_end && (row_q == ROW2);
        frame_start = start_q || frame_wrap;
        cnt_d       = cnt_q;
        row_d       = row_q;
        if (!start_q) begin
            cnt_d = row_end ? '0 : cnt_q + 1'b1;
            if (row_end) begin
                row_d = (row_q == ROW2) ? ROW0 : row_q + 2'd1;
            end
        end
        state_d = (cnt_d < CW'(BLANK)) ? StBlank : StShow;

        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (cells_n[2*i +: 2] == CELL_BAD) bad = 1'b1;
        end

        snap_d     = snap_q;
        stat_n_d   = stat_n_q;
        code_err_d = code_err;
        if (frame_start) begin
            snap_d     = cells_n;
            stat_n_d   = {p1_win_n, p2_win_n, grid_full_n};
            code_err_d = code_err | bad;
        end

        blink_d = blink_q;
        phase_d = phase_q;
        if (frame_wrap) begin
            if (blink_q == BLINK_LAST) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end

        p1w       = ~stat_n_d[2];
        p2w       = ~stat_n_d[1];
        draw      = ~stat_n_d[0] & ~p1w & ~p2w;
        red_off   = phase_d & (p1w | draw);
        green_off = phase_d & (p2w | draw);
    end

`ifdef DISPLAY_DIM_EN
    logic [1:0] pwm_q, pwm_d;

    assign pwm_d  = pwm_q + 2'd1;
    assign col_en = (pwm_d <= bright);

    always_ff @(posedge clk) begin
        if (reset) pwm_q <= '0;
        else       pwm_q <= pwm_d;
    end
`else
    assign col_en = 1'b1;
`endif

    display_row_mux u_row_mux (
        .row       (row_d),
        .snap      (snap_d),
        .red_off   (red_off),
        .green_off (green_off),
        .red       (mux_red),
        .green     (mux_green)
    );

    always_comb begin
        row_sel_d   = '0;
        col_red_d   = '0;
        col_green_d = '0;
        if (state_d == StShow) begin
            row_sel_d = 3'b001 << row_d;
            if (col_en) begin
                col_red_d   = mux_red;
                col_green_d = mux_green;
            end
        end
    end

endmodule

// File: doc/board_display_scan.md
Name: board_display_scan

Overview:
- Reader side of the game core's board outputs: consumes the nine 2-bit active-low cell codes and the active-low status lines.
- Drives a row-multiplexed 3x3 bicolour LED matrix: red = player 1, green = player 2.
- Adds anti-ghosting blanking, tear-free frame snapshots, winner/draw blinking, and sticky detection of illegal cell codes.
- Sits between the game core and the board pins.

Parameters:
- PRESCALE, 1000, clock cycles per row period (total, including blanking); must be >= BLANK+2.
- BLANK, 2, cycles at the start of each row period with all columns off.
- BLINK_FRAMES, 32, full frames per blink half-period; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cells_n  input  18  packed cell codes; bits [17:16]=a … [1:0]=i; per cell {p1_n,p2_n}, active low
- p1_win_n  input  1  player 1 win, active low
- p2_win_n  input  1  player 2 win, active low
- grid_full_n  input  1  grid full, active low
- row_sel  output  3  one-hot row drive, active high; row0=a,b,c; row1=d,e,f; row2=g,h,i
- col_red  output  3  red column drive, active high; bit0=left column
- col_green  output  3  green column drive, active high
- frame_tick  output  1  one-cycle pulse at the start of each frame (row0 entry)
- code_err  output  1  sticky flag: an illegal cell code was snapshotted

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: row_sel=000, col_red=000, col_green=000, frame_tick=0, code_err=0, prescaler=0, row=0, blink counter=0, blink phase=0, snapshot cleared to 2'b11 (empty).
- State machine per row period: BLANK -> SHOW.
  - BLANK lasts BLANK cycles: row_sel=000 and all columns 000.
  - SHOW lasts PRESCALE-BLANK cycles: row_sel is one-hot for the current row; columns are driven from the snapshot.
  - At the end of SHOW, row advances 0->1->2->0 and the machine re-enters BLANK.
- Prescaler width is $clog2(PRESCALE). It counts 0..PRESCALE-1 and wraps; no other terminal value.
- Snapshot:
  - On the first cycle after reset, and on every row2->row0 wrap, cells_n and the three status lines are registered into the snapshot.
  - frame_tick pulses in that same cycle.
  - Input changes mid-frame are not visible until the next frame.
- Cell decode (snapshot, per cell):
  - 11 -> both colours off.
  - 01 -> red.
  - 10 -> green.
  - 00 -> illegal: both colours off, and code_err is set and held until reset.
- Blink:
  - The blink counter counts frames 0..BLINK_FRAMES-1.
  - At wrap, the blink phase toggles.
  - While phase=1, masking applies as follows:
    - p1 win snapshotted: red cells off.
    - p2 win snapshotted: green cells off.
    - Both wins snapshotted: both colours off.
    - grid_full with no win: all cells off.
  - With no win and grid not full, no masking; the blink counter still runs.
- Output timing: outputs are registered; column data appears in the same cycle row_sel goes one-hot.
- Mid-operation reset: reset asserted in any state returns all state to reset values on the next edge; the next frame restarts at row0 BLANK with a fresh snapshot.

Optional Feature:
- Macro: DISPLAY_DIM_EN.
- Defined:
  - Adds input port bright (2 bits).
  - The SHOW phase is PWM-gated by a free-running 2-bit counter: columns are enabled only while counter < bright+1, giving duty 1/4..4/4.
  - row_sel still follows the state machine.
- Undefined: the port is absent and columns are enabled for all of SHOW (full brightness).

Decomposition:
- Shared package holds:
  - cell code localparams: CELL_EMPTY=2'b11, CELL_P1=2'b01, CELL_P2=2'b10, CELL_BAD=2'b00;
  - row index constants;
  - the cell_decode function.
- One natural sub-module: display_row_mux. It takes a row index, the snapshotted 18 bits, and the blink masks, and returns the two 3-bit column words (combinational). The FSM, counters and snapshot stay in the top.

Test Plan:
- Basic scan: PRESCALE=8, BLANK=2; reset, then cells_n all 11 -> row_sel sequence 000,000,001×6,000,000,010×6,000,000,100×6, repeating; columns always 000; frame_tick every 24 cycles.
- Colour decode: a=01, e=10, i=01, rest 11 -> row0 col_red=001, row1 col_green=010, row2 col_red=100; code_err=0.
- Mid-frame change: change cells_n during row1 -> display unchanged until the cycle after frame_tick.
- P1 win blink: BLINK_FRAMES=1, p1_win_n=0, a=01, b=10 -> col_red bit0 alternates on/off each frame; col_green bit1 steady on.
- Illegal code and reset: cell c=00 -> that LED dark, code_err=1 and held after c returns to 11. Assert reset for one cycle during row2 SHOW -> all outputs 000 and code_err=0 next cycle; scan restarts at row0 BLANK.
- DISPLAY_DIM_EN with bright=00 -> columns lit 1 of every 4 SHOW cycles; with bright=11 -> columns lit for all SHOW cycles.
